// File: rtl/rformat_pkg.sv
// ============================================================================
// Module : rformat_pkg
// Brief  : ALU opcodes and W-stage flag type for the R-format execute block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rformat_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef struct packed {
    logic zero;
    logic overflow;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/rformat_alu.sv
// ============================================================================
// Module : rformat_alu
// Brief  : Combinational 8-function ALU with zero and signed-overflow flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rformat_alu
  import rformat_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  // Only the low bits of rt select the shift distance.
  assign shamt = rt_i[SH_W-1:0];
  assign sum   = rs_i + rt_i;
  assign diff  = rs_i - rt_i;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o   = sum;
        overflow_o = (rs_i[MSB] == rt_i[MSB]) && (sum[MSB] != rs_i[MSB]);
      end
      OP_SUB: begin
        result_o   = diff;
        overflow_o = (rs_i[MSB] != rt_i[MSB]) && (diff[MSB] != rs_i[MSB]);
      end
      OP_AND: result_o = rs_i & rt_i;
      OP_OR:  result_o = rs_i | rt_i;
      OP_XOR: result_o = rs_i ^ rt_i;
      OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(rs_i) < $signed(rt_i))};
      OP_SLL: result_o = rs_i << shamt;
      OP_SRL: result_o = rs_i >> shamt;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/rformat_exec_regfile.sv
// ============================================================================
// Module : rformat_exec_regfile
// Brief  : Register file, ALU and registered write-back stage with forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rformat_exec_regfile
  import rformat_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_input,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_address,
  input  logic [ADDR_W-1:0] rt_address,
  input  logic [ADDR_W-1:0] out_address,
  input  logic [2:0]        ALU_operation,
  input  logic              write_enabled,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_address_q,
  output logic              zero_flag,
  output logic              overflow_flag,
  input  logic [ADDR_W-1:0] dbg_address,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  flags_t            flags_q;

  logic              accept;
  logic              retire;
  logic              ret_wr;
  logic              load_wr;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] alu_result;
  flags_t            alu_flags;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = valid_q && out_ready;
  assign ret_wr   = retire && we_q && (addr_q != '0);
  assign load_wr  = load_en && (load_address != '0);

  // Operand select: retiring result beats same-cycle load beats stored value.
  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] a);
    if (a == '0)                     return '0;
    if (ret_wr && (addr_q == a))     return data_q;
    if (load_wr && (load_address == a)) return load_data;
    return regs_q[a];
  endfunction

  assign rs_val = operand(rs_address);
  assign rt_val = operand(rt_address);

  rformat_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .rs_i       (rs_val),
    .rt_i       (rt_val),
    .op_i       (ALU_operation),
    .result_o   (alu_result),
    .zero_o     (alu_flags.zero),
    .overflow_o (alu_flags.overflow)
  );

  // Register 0 is never written so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (ret_wr && (addr_q == ADDR_W'(i)))
          regs_q[i] <= data_q;
        else if (load_wr && (load_address == ADDR_W'(i)))
          regs_q[i] <= load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      flags_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= alu_result;
      addr_q  <= out_address;
      we_q    <= write_enabled;
      flags_q <= alu_flags;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_address_q = addr_q;
  assign zero_flag     = flags_q.zero;
  assign overflow_flag = flags_q.overflow;
  assign dbg_data      = regs_q[dbg_address];

endmodule

`default_nettype wire

// File: tb/tb_rformat_exec_regfile.sv
// ============================================================================
// Module : tb_rformat_exec_regfile
// Brief  : Self-checking bench: vector table, directed corner cases, random run.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rformat_exec_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_input;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs_address, rt_address, out_address;
  logic [2:0]    ALU_operation;
  logic          write_enabled;
  logic          load_en;
  logic [AW-1:0] load_address;
  logic [DW-1:0] load_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_address_q;
  logic          zero_flag, overflow_flag;
  logic [AW-1:0] dbg_address;
  logic [DW-1:0] dbg_data;

  rformat_exec_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset_input   (reset_input),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rs_address    (rs_address),
    .rt_address    (rt_address),
    .out_address   (out_address),
    .ALU_operation (ALU_operation),
    .write_enabled (write_enabled),
    .load_en       (load_en),
    .load_address  (load_address),
    .load_data     (load_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_address_q (out_address_q),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag),
    .dbg_address   (dbg_address),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Architectural model: register contents plus the one pending W-stage result.
  logic [DW-1:0] m_regs [32];
  logic          m_v;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_we, m_z, m_o;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_v = 0; m_data = '0; m_addr = '0; m_we = 0; m_z = 0; m_o = 0;
  endtask

  // Reference ALU from plain signed/unsigned arithmetic.
  task automatic alu_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] r, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[DW-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; r = s[DW-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
  endtask

  function automatic logic [DW-1:0] opnd(input logic [AW-1:0] a, input logic ret);
    if (a == 0) return '0;
    if (ret && m_we && m_addr == a) return m_data;
    if (load_en && load_address == a) return load_data;
    return m_regs[a];
  endfunction

  // One clock: inputs already driven; check handshake, advance model, check outputs.
  task automatic cycle();
    logic acc, ret, o;
    logic [DW-1:0] a, b, r;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_v || out_ready)});
    acc = in_valid && (!m_v || out_ready);
    ret = m_v && out_ready;
    a = opnd(rs_address, ret);
    b = opnd(rt_address, ret);
    alu_ref(ALU_operation, a, b, r, o);
    @(posedge clk);
    #1;
    if (load_en && load_address != 0) m_regs[load_address] = load_data;
    if (ret && m_we && m_addr != 0) m_regs[m_addr] = m_data;
    if (acc) begin
      m_v = 1; m_data = r; m_addr = out_address; m_we = write_enabled;
      m_z = (r == 0); m_o = o;
    end else if (ret) m_v = 0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("out_data", out_data, m_data);
      chk("out_address_q", {27'd0, out_address_q}, {27'd0, m_addr});
      chk("flags", {30'd0, zero_flag, overflow_flag}, {30'd0, m_z, m_o});
    end
    chk("dbg_data", dbg_data, m_regs[dbg_address]);
  endtask

  task automatic idle();
    in_valid = 0; load_en = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [2:0] op, input int rs, input int rt, input int od, input logic we);
    in_valid = 1; ALU_operation = op;
    rs_address = AW'(rs); rt_address = AW'(rt); out_address = AW'(od); write_enabled = we;
  endtask

  task automatic load(input int ad, input logic [DW-1:0] d);
    load_en = 1; load_address = AW'(ad); load_data = d;
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b, res;
    logic          z, o;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};
    vecs[2]  = '{3'd1, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0, 1'b1};
    vecs[3]  = '{3'd1, 32'd3,         32'd3,         32'd0,         1'b1, 1'b0};
    vecs[4]  = '{3'd2, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b0};
    vecs[5]  = '{3'd3, 32'h0F000000,  32'h000000F0,  32'h0F0000F0,  1'b0, 1'b0};
    vecs[6]  = '{3'd4, 32'hAAAAAAAA,  32'hFFFFFFFF,  32'h55555555,  1'b0, 1'b0};
    vecs[7]  = '{3'd5, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0};
    vecs[8]  = '{3'd5, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b1, 1'b0};
    vecs[9]  = '{3'd6, 32'd1,         32'd33,        32'd2,         1'b0, 1'b0};
    vecs[10] = '{3'd7, 32'h80000000,  32'hFFFFFFFF,  32'd1,         1'b0, 1'b0};
    vecs[11] = '{3'd0, 32'h7FFFFFFF,  32'h7FFFFFFF,  32'hFFFFFFFE,  1'b0, 1'b1};

    reset_input = 0; idle(); dbg_address = '0;
    ALU_operation = '0; rs_address = '0; rt_address = '0; out_address = '0;
    write_enabled = 0; load_address = '0; load_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_address_q", {27'd0, out_address_q}, 32'd0);
    chk("reset flags", {30'd0, zero_flag, overflow_flag}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset dbg_data", dbg_data, 32'd0);
    reset_input = 1;
    @(posedge clk); #1;

    // Basic add with preload, then observe write-back through dbg.
    load(1, 32'd31); cycle();
    load(2, 32'd47); cycle();
    idle(); issue(3'd0, 1, 2, 3, 1); cycle();
    chk("add result", out_data, 32'd78);
    idle(); dbg_address = 3; cycle();
    chk("add writeback", dbg_data, 32'd78);

    // Back-to-back dependency through the forwarding path.
    issue(3'd0, 1, 2, 3, 1); cycle();
    issue(3'd1, 3, 1, 4, 1); cycle();
    idle(); dbg_address = 4; cycle();
    chk("forwarded sub", dbg_data, 32'd47);

    // Operation table.
    foreach (vecs[k]) begin
      idle(); load(10, vecs[k].a); cycle();
      idle(); load(11, vecs[k].b); cycle();
      idle(); issue(vecs[k].op, 10, 11, 12, 1); cycle();
      chk($sformatf("vec%0d result", k), out_data, vecs[k].res);
      chk($sformatf("vec%0d flags", k), {30'd0, zero_flag, overflow_flag},
          {30'd0, vecs[k].z, vecs[k].o});
    end
    idle(); cycle();

    // Backpressure: result held, no write, exactly one retire.
    load(5, 32'd100); cycle();
    idle(); issue(3'd0, 1, 2, 5, 1); cycle();
    idle(); out_ready = 0; dbg_address = 5;
    for (int i = 0; i < 3; i++) begin
      issue(3'd4, 1, 1, 6, 1); cycle();
      chk("bp stall data", out_data, 32'd78);
      chk("bp no write", dbg_data, 32'd100);
    end
    idle(); cycle();
    chk("bp retire", dbg_data, 32'd78);
    chk("bp single retire", {31'd0, out_valid}, 32'd0);

    // Register 0 can never hold a non-zero value.
    issue(3'd0, 1, 2, 0, 1); load(0, 32'd5); cycle();
    idle(); dbg_address = 0; cycle();
    chk("r0 stays zero", dbg_data, 32'd0);
    issue(3'd0, 0, 0, 7, 1); cycle();
    chk("r0 reads zero", out_data, 32'd0);
    issue(3'd1, 1, 1, 8, 1); cycle();
    chk("sub zero flag", {31'd0, zero_flag}, 32'd1);
    idle(); cycle();

    // Simultaneous retire and load.
    load(20, 32'd9); cycle();
    idle(); issue(3'd3, 20, 0, 5, 1); cycle();
    idle(); load(5, 32'd7); dbg_address = 5; cycle();
    chk("retire beats load", dbg_data, 32'd9);
    idle(); issue(3'd3, 20, 0, 5, 1); cycle();
    idle(); load(6, 32'd7); cycle();
    chk("both written r5", dbg_data, 32'd9);
    idle(); dbg_address = 6; cycle();
    chk("both written r6", dbg_data, 32'd7);

    // Random traffic with heavy address reuse.
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      ALU_operation = 3'($urandom);
      rs_address = AW'($urandom_range(0, 7));
      rt_address = AW'($urandom_range(0, 7));
      out_address = AW'($urandom_range(0, 7));
      write_enabled = ($urandom_range(0, 9) != 0);
      load_en = ($urandom_range(0, 3) == 0);
      load_address = AW'($urandom_range(0, 7));
      load_data = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      dbg_address = AW'($urandom_range(0, 7));
      cycle();
    end

    // Reset mid-flight.
    idle(); issue(3'd0, 1, 2, 9, 1); out_ready = 0; cycle();
    chk("pre-reset valid", {31'd0, out_valid}, 32'd1);
    #2; reset_input = 0; idle(); dbg_address = 1;
    #1;
    model_reset();
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset out_data", out_data, 32'd0);
    chk("mid reset dbg r1", dbg_data, 32'd0);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    reset_input = 1;
    @(posedge clk); #1;
    issue(3'd0, 0, 0, 1, 1); cycle();
    idle(); cycle();
    chk("post reset r1", dbg_data, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
